// File: rtl/multi_vending_machine.sv
// ============================================================================
// multi_vending_machine -- coin-accepting, multi-product vending controller
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module multi_vending_machine #(
    parameter int                            N_ITEMS    = 4,
    parameter int                            CREDIT_W   = 8,
    parameter int                            MAX_CREDIT = 50,
    parameter logic [N_ITEMS*CREDIT_W-1:0]   PRICES     = {8'd15, 8'd12, 8'd10, 8'd7},
    parameter int                            STOCK_W    = 4,
    parameter int                            INIT_STOCK = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       coin_valid,
    input  logic [1:0]                 coin_code,
    input  logic                       sel_valid,
    input  logic [$clog2(N_ITEMS)-1:0] sel_id,
    input  logic                       refund,
    output logic [CREDIT_W-1:0]        credit,
    output logic                       vend_valid,
    output logic [$clog2(N_ITEMS)-1:0] vend_id,
    output logic                       change_pulse,
    output logic                       coin_reject,
    output logic                       sold_out,
    output logic                       need_more,
    output logic                       busy
);

    localparam int SEL_W = $clog2(N_ITEMS);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_CHANGE = 1'b1
    } state_t;

    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [STOCK_W-1:0]  r_stock [N_ITEMS];
    logic                r_vend_valid;
    logic [SEL_W-1:0]    r_vend_id;
    logic                r_change_pulse;
    logic                r_coin_reject;
    logic                r_sold_out;
    logic                r_need_more;

    logic                w_sel_ok;
    logic [SEL_W-1:0]    w_idx;
    logic [CREDIT_W-1:0] w_price;
    logic [CREDIT_W-1:0] w_coin_val;
    logic                w_coin_legal;
    logic [CREDIT_W:0]   w_credit_sum;
    logic                w_coin_ok;

    // Out-of-range selections are steered to item 0 for the lookups but
    // flagged so they are reported as sold out.
    assign w_sel_ok = (32'(sel_id) < N_ITEMS);
    assign w_idx    = w_sel_ok ? sel_id : '0;
    assign w_price  = PRICES[w_idx*CREDIT_W +: CREDIT_W];

    always_comb begin
        w_coin_val   = '0;
        w_coin_legal = 1'b1;
        case (coin_code)
            2'b00:   w_coin_val = CREDIT_W'(1);
            2'b01:   w_coin_val = CREDIT_W'(5);
            2'b10:   w_coin_val = CREDIT_W'(10);
            default: w_coin_legal = 1'b0;
        endcase
    end

    assign w_credit_sum = {1'b0, r_credit} + {1'b0, w_coin_val};
    assign w_coin_ok    = w_coin_legal && (w_credit_sum <= (CREDIT_W+1)'(MAX_CREDIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_credit       <= '0;
            for (int i = 0; i < N_ITEMS; i++) begin
                r_stock[i] <= STOCK_W'(INIT_STOCK);
            end
            r_vend_valid   <= 1'b0;
            r_vend_id      <= '0;
            r_change_pulse <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_sold_out     <= 1'b0;
            r_need_more    <= 1'b0;
        end else begin
            r_vend_valid   <= 1'b0;
            r_change_pulse <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_sold_out     <= 1'b0;
            r_need_more    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Refund outranks selection, which outranks coin entry.
                    if (refund) begin
                        if (r_credit != '0) begin
                            r_state <= ST_CHANGE;
                        end
                    end else if (sel_valid) begin
                        if (!w_sel_ok || (r_stock[w_idx] == '0)) begin
                            r_sold_out <= 1'b1;
                        end else if (r_credit < w_price) begin
                            r_need_more <= 1'b1;
                        end else begin
                            r_vend_valid   <= 1'b1;
                            r_vend_id      <= w_idx;
                            r_credit       <= r_credit - w_price;
                            r_stock[w_idx] <= r_stock[w_idx] - STOCK_W'(1);
                            if (r_credit != w_price) begin
                                r_state <= ST_CHANGE;
                            end
                        end
                    end
                    if (coin_valid) begin
                        if (w_coin_ok && !refund && !sel_valid) begin
                            r_credit <= w_credit_sum[CREDIT_W-1:0];
                        end else begin
                            r_coin_reject <= 1'b1;
                        end
                    end
                end
                ST_CHANGE: begin
                    if (coin_valid) begin
                        r_coin_reject <= 1'b1;
                    end
                    if (r_credit != '0) begin
                        r_change_pulse <= 1'b1;
                        r_credit       <= r_credit - CREDIT_W'(1);
                    end
                    // Leave on the edge that pays out the last unit.
                    if (r_credit <= CREDIT_W'(1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign credit       = r_credit;
    assign vend_valid   = r_vend_valid;
    assign vend_id      = r_vend_id;
    assign change_pulse = r_change_pulse;
    assign coin_reject  = r_coin_reject;
    assign sold_out     = r_sold_out;
    assign need_more    = r_need_more;
    assign busy         = (r_state == ST_CHANGE);

endmodule

`default_nettype wire

// File: tb/tb_multi_vending_machine.sv
// ============================================================================
// tb_multi_vending_machine -- directed vector bench for multi_vending_machine
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module tb_multi_vending_machine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_code = 2'b00;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_id = 2'b00;
    logic       refund = 1'b0;
    logic [7:0] credit;
    logic       vend_valid;
    logic [1:0] vend_id;
    logic       change_pulse;
    logic       coin_reject;
    logic       sold_out;
    logic       need_more;
    logic       busy;

    int tests = 0;
    int fails = 0;

    multi_vending_machine dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin_code    (coin_code),
        .sel_valid    (sel_valid),
        .sel_id       (sel_id),
        .refund       (refund),
        .credit       (credit),
        .vend_valid   (vend_valid),
        .vend_id      (vend_id),
        .change_pulse (change_pulse),
        .coin_reject  (coin_reject),
        .sold_out     (sold_out),
        .need_more    (need_more),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cv;
        logic [1:0] cc;
        logic       sv;
        logic [1:0] sid;
        logic       rf;
        logic [7:0] credit;
        logic       vv;
        logic [1:0] vid;
        logic       cp;
        logic       cr;
        logic       so;
        logic       nm;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic cv, input logic [1:0] cc, input logic sv,
                                input logic [1:0] sid, input logic rf, input logic [7:0] cred,
                                input logic vv, input logic [1:0] vid, input logic cp,
                                input logic cr, input logic so, input logic nm, input logic bz);
        vec_t v;
        v.cv = cv; v.cc = cc; v.sv = sv; v.sid = sid; v.rf = rf;
        v.credit = cred; v.vv = vv; v.vid = vid; v.cp = cp;
        v.cr = cr; v.so = so; v.nm = nm; v.busy = bz;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, return 1ns after the rising edge.
    task automatic cyc(input logic cv, input logic [1:0] cc, input logic sv,
                       input logic [1:0] sid, input logic rf);
        @(negedge clk);
        coin_valid = cv; coin_code = cc; sel_valid = sv; sel_id = sid; refund = rf;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
    endtask

    initial begin
        int pulses;
        int first_p;
        int last_p;

        // Prices: item0=7, item1=10, item2=12, item3=15; stock 3 each.
        vecs.push_back(mk(0,0,0,0,0,  0, 0,0,0,0,0,0,0));
        vecs.push_back(mk(1,2,0,0,0, 10, 0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0, 11, 0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,1,0,  1, 1,1,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,  0, 0,0,1,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,  0, 0,0,0,0,0,0,0));
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(mk(1,1,0,0,0, 5, 0,0,0,0,0,0,0));
            vecs.push_back(mk(1,0,0,0,0, 6, 0,0,0,0,0,0,0));
            vecs.push_back(mk(1,0,0,0,0, 7, 0,0,0,0,0,0,0));
            vecs.push_back(mk(0,0,1,0,0, 0, 1,0,0,0,0,0,0));
        end
        vecs.push_back(mk(1,1,0,0,0, 5, 0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0, 6, 0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0, 7, 0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0, 7, 0,0,0,0,1,0,0));
        vecs.push_back(mk(0,0,1,3,0, 7, 0,0,0,0,0,1,0));
        vecs.push_back(mk(1,3,0,0,0, 7, 0,0,0,1,0,0,0));
        vecs.push_back(mk(1,0,1,1,1, 7, 0,0,0,1,0,0,1));
        vecs.push_back(mk(1,0,0,0,0, 6, 0,0,1,1,0,0,1));
        for (int c = 5; c >= 1; c--) begin
            vecs.push_back(mk(0,0,0,0,0, 8'(c), 0,0,1,0,0,0,1));
        end
        vecs.push_back(mk(0,0,0,0,0,  0, 0,0,1,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,  0, 0,0,0,0,0,0,0));

        // Reset state, observed while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check("reset credit", credit, 0);
        check("reset flags", {vend_valid, change_pulse, coin_reject, sold_out, need_more, busy}, 0);
        check("reset vend_id", vend_id, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            cyc(vecs[i].cv, vecs[i].cc, vecs[i].sv, vecs[i].sid, vecs[i].rf);
            check($sformatf("vec%0d credit", i), credit, vecs[i].credit);
            check($sformatf("vec%0d flags vv/cp/cr/so/nm/busy", i),
                  {vend_valid, change_pulse, coin_reject, sold_out, need_more, busy},
                  {vecs[i].vv, vecs[i].cp, vecs[i].cr, vecs[i].so, vecs[i].nm, vecs[i].busy});
            if (vecs[i].vv) begin
                check($sformatf("vec%0d vend_id", i), vend_id, vecs[i].vid);
            end
        end

        // Refund of 10 units: ten consecutive change pulses.
        cyc(1, 2'b01, 0, 0, 0);
        cyc(1, 2'b01, 0, 0, 0);
        check("refund pre credit", credit, 10);
        cyc(0, 0, 0, 0, 1);
        check("refund busy", busy, 1);
        pulses = 0; first_p = -1; last_p = -1;
        for (int k = 0; k < 20; k++) begin
            idle();
            if (change_pulse) begin
                pulses++;
                if (first_p < 0) first_p = k;
                last_p = k;
            end
        end
        check("refund pulse count", pulses, 10);
        check("refund pulse span", last_p - first_p, 9);
        check("refund end credit", credit, 0);
        check("refund end busy", busy, 0);

        // Credit ceiling and invalid coin.
        for (int k = 0; k < 5; k++) cyc(1, 2'b10, 0, 0, 0);
        check("limit credit 50", credit, 50);
        cyc(1, 2'b00, 0, 0, 0);
        check("limit overflow reject", coin_reject, 1);
        check("limit credit held", credit, 50);
        cyc(1, 2'b11, 0, 0, 0);
        check("invalid coin reject", coin_reject, 1);
        check("invalid coin credit", credit, 50);

        // Reset aborts a refund in progress and restores stock.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 2'b10, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        pulses = 0;
        for (int k = 0; k < 10 && pulses < 3; k++) begin
            idle();
            if (change_pulse) pulses++;
        end
        check("midchange pulses before rst", pulses, 3);
        check("midchange credit before rst", credit, 7);
        #2 rst = 1'b1;
        #1;
        check("midchange async credit", credit, 0);
        check("midchange async busy", busy, 0);
        check("midchange async pulse", change_pulse, 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            idle();
            if (change_pulse || busy) pulses++;
        end
        check("post rst no pulses", pulses, 0);
        check("post rst credit", credit, 0);
        cyc(1, 2'b01, 0, 0, 0);
        cyc(1, 2'b00, 0, 0, 0);
        cyc(1, 2'b00, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check("stock restored vend", vend_valid, 1);
        check("stock restored sold_out", sold_out, 0);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
